// File: rtl/tetris_move_ctrl.sv
// tetris_move_ctrl: sequences all motion of the falling piece.
// Gravity ticks and player left/right/soft-drop requests are arbitrated in
// IDLE. One candidate position at a time goes to the board collision checker
// over a chk_req/chk_ack handshake. The move is committed only when the
// checker reports it legal. An illegal downward move locks the piece, and the
// piece then respawns at (SPAWN_X, SPAWN_Y).
// Optional build macro TETRIS_HARD_DROP_EN adds a hard_drop_req input. That
// input chains down checks back to back until the piece lands.
module tetris_move_ctrl #(
    parameter int GRAV_DIV = 25000000,   // clk cycles per gravity tick, >= 2
    parameter int X_MAX    = 9,          // rightmost legal column
    parameter int SPAWN_X  = 5,          // spawn column
    parameter int SPAWN_Y  = 0           // spawn row
) (
    input  logic       clk,
    input  logic       rst,
`ifdef TETRIS_HARD_DROP_EN
    input  logic       hard_drop_req,
`endif
    input  logic       left_req,
    input  logic       right_req,
    input  logic       drop_req,
    output logic       chk_req,
    output logic [4:0] chk_x,
    output logic [4:0] chk_y,
    input  logic       chk_ack,
    input  logic       chk_ok,
    output logic [4:0] pos_x,
    output logic [4:0] pos_y,
    output logic       lock_pulse,
    output logic       spawn_pulse,
    output logic       busy
);

    localparam int         CNT_W    = (GRAV_DIV > 2) ? $clog2(GRAV_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAV_DIV - 1);
    localparam logic [4:0] X_MAX_C   = 5'(X_MAX);
    localparam logic [4:0] SPAWN_X_C = 5'(SPAWN_X);
    localparam logic [4:0] SPAWN_Y_C = 5'(SPAWN_Y);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;
    localparam logic [1:0] ST_SPAWN = 2'd3;

    logic [1:0]       state_q,     state_d;
    logic [4:0]       pos_x_q,     pos_x_d;
    logic [4:0]       pos_y_q,     pos_y_d;
    logic [4:0]       cand_x_q,    cand_x_d;
    logic [4:0]       cand_y_q,    cand_y_d;
    logic             chk_req_q,   chk_req_d;
    logic             down_q,      down_d;       // candidate is a downward move
    logic [CNT_W-1:0] grav_cnt_q,  grav_cnt_d;
    logic             grav_pend_q, grav_pend_d;
`ifdef TETRIS_HARD_DROP_EN
    logic             hd_mode_q,   hd_mode_d;    // chaining down checks
`endif

    // Launch request built by the IDLE arbiter, applied below the case
    logic             launch_en;
    logic             launch_down;
    logic [4:0]       launch_x;
    logic [4:0]       launch_y;
    logic             grav_clr;
    logic             grav_tick;

    assign grav_tick = (grav_cnt_q == CNT_LAST);

    // Next-state logic: gravity timer, IDLE arbitration, handshake and lock/spawn
    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        chk_req_d   = chk_req_q;
        down_d      = down_q;
`ifdef TETRIS_HARD_DROP_EN
        hd_mode_d   = hd_mode_q;
`endif
        launch_en   = 1'b0;
        launch_down = 1'b0;
        launch_x    = pos_x_q;
        launch_y    = pos_y_q;
        grav_clr    = 1'b0;

        // Free-running gravity divider, independent of the FSM state
        grav_cnt_d = grav_tick ? '0 : grav_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
`ifdef TETRIS_HARD_DROP_EN
                if (hard_drop_req) begin
                    launch_en   = 1'b1;
                    launch_down = 1'b1;
                    launch_y    = pos_y_q + 5'd1;
                    grav_clr    = 1'b1;
                    hd_mode_d   = 1'b1;
                end else
`endif
                if (grav_pend_q) begin
                    launch_en   = 1'b1;
                    launch_down = 1'b1;
                    launch_y    = pos_y_q + 5'd1;
                    grav_clr    = 1'b1;
                end else if (drop_req) begin
                    launch_en   = 1'b1;
                    launch_down = 1'b1;
                    launch_y    = pos_y_q + 5'd1;
                end else if (left_req) begin
                    // At the wall the request is swallowed without a handshake
                    if (pos_x_q != 5'd0) begin
                        launch_en = 1'b1;
                        launch_x  = pos_x_q - 5'd1;
                    end
                end else if (right_req) begin
                    if (pos_x_q != X_MAX_C) begin
                        launch_en = 1'b1;
                        launch_x  = pos_x_q + 5'd1;
                    end
                end
            end

            ST_CHECK: begin
                if (chk_ack) begin
                    if (chk_ok) begin
                        pos_x_d = cand_x_q;
                        pos_y_d = cand_y_q;
`ifdef TETRIS_HARD_DROP_EN
                        if (hd_mode_q) begin
                            // Keep the request up and propose the next row
                            cand_y_d = cand_y_q + 5'd1;
                        end else begin
                            chk_req_d = 1'b0;
                            state_d   = ST_IDLE;
                        end
`else
                        chk_req_d = 1'b0;
                        state_d   = ST_IDLE;
`endif
                    end else begin
                        chk_req_d = 1'b0;
                        state_d   = down_q ? ST_LOCK : ST_IDLE;
`ifdef TETRIS_HARD_DROP_EN
                        hd_mode_d = 1'b0;
`endif
                    end
                end
            end

            ST_LOCK: begin
                // Load spawn position on leaving LOCK so SPAWN already shows it
                pos_x_d = SPAWN_X_C;
                pos_y_d = SPAWN_Y_C;
                state_d = ST_SPAWN;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch_en) begin
            cand_x_d  = launch_x;
            cand_y_d  = launch_y;
            down_d    = launch_down;
            chk_req_d = 1'b1;
            state_d   = ST_CHECK;
        end

        // A fresh tick wins over the clear; a tick while pending is absorbed
        if (grav_tick) begin
            grav_pend_d = 1'b1;
        end else if (grav_clr) begin
            grav_pend_d = 1'b0;
        end else begin
            grav_pend_d = grav_pend_q;
        end
    end

    // State registers with asynchronous reset to the spawn position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pos_x_q     <= SPAWN_X_C;
            pos_y_q     <= SPAWN_Y_C;
            cand_x_q    <= 5'd0;
            cand_y_q    <= 5'd0;
            chk_req_q   <= 1'b0;
            down_q      <= 1'b0;
            grav_cnt_q  <= '0;
            grav_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            chk_req_q   <= chk_req_d;
            down_q      <= down_d;
            grav_cnt_q  <= grav_cnt_d;
            grav_pend_q <= grav_pend_d;
        end
    end

`ifdef TETRIS_HARD_DROP_EN
    // Hard-drop mode flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hd_mode_q <= 1'b0;
        end else begin
            hd_mode_q <= hd_mode_d;
        end
    end
`endif

    assign chk_req     = chk_req_q;
    assign chk_x       = cand_x_q;
    assign chk_y       = cand_y_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign lock_pulse  = (state_q == ST_LOCK);
    assign spawn_pulse = (state_q == ST_SPAWN);
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tetris_move_ctrl.sv
// Scoreboard bench for tetris_move_ctrl (GRAV_DIV=64 so directed tests fit
// between gravity ticks). A responder plays the collision checker from a queue
// of expected candidates. An event monitor checks lock/spawn pulses against a
// second queue.
module tb_tetris_move_ctrl;

    localparam int GD = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left_req = 1'b0, right_req = 1'b0, drop_req = 1'b0;
    logic       chk_ack = 1'b0, chk_ok = 1'b0;
`ifdef TETRIS_HARD_DROP_EN
    logic       hard_drop_req = 1'b0;
`endif
    logic       chk_req, lock_pulse, spawn_pulse, busy;
    logic [4:0] chk_x, chk_y, pos_x, pos_y;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] x;
        logic [4:0] y;
        logic       ok;
        int         dly;
    } chk_t;

    typedef struct {
        logic       is_lock;
        logic [4:0] x;
        logic [4:0] y;
    } evt_t;

    chk_t chk_q[$];
    evt_t evt_q[$];

    always #5 clk = ~clk;

    tetris_move_ctrl #(.GRAV_DIV(GD), .X_MAX(9), .SPAWN_X(5), .SPAWN_Y(0)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef TETRIS_HARD_DROP_EN
        .hard_drop_req(hard_drop_req),
`endif
        .left_req    (left_req),
        .right_req   (right_req),
        .drop_req    (drop_req),
        .chk_req     (chk_req),
        .chk_x       (chk_x),
        .chk_y       (chk_y),
        .chk_ack     (chk_ack),
        .chk_ok      (chk_ok),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .lock_pulse  (lock_pulse),
        .spawn_pulse (spawn_pulse),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_chk(input logic [4:0] x, input logic [4:0] y, input logic ok, input int dly);
        chk_t e;
        e.x = x; e.y = y; e.ok = ok; e.dly = dly;
        chk_q.push_back(e);
    endtask

    task automatic push_evt(input logic is_lock, input logic [4:0] x, input logic [4:0] y);
        evt_t e;
        e.is_lock = is_lock; e.x = x; e.y = y;
        evt_q.push_back(e);
    endtask

    task automatic do_reset();
        check("queues_drained", chk_q.size() + evt_q.size(), 0);
        chk_q.delete();
        evt_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_pos(input logic [4:0] x, input logic [4:0] y, input int limit, input string name);
        int n = 0;
        while (!(pos_x == x && pos_y == y) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, {pos_x, pos_y}, {x, y});
    endtask

    task automatic count_req(input int n, input string name);
        int c = 0;
        repeat (n) begin
            @(negedge clk);
            if (chk_req) c++;
        end
        check(name, c, 0);
    endtask

    // Checker responder: pops the expected candidate and acks after its delay
    initial begin : responder
        bit   in_hs;
        int   wait_cnt;
        logic cur_ok;
        chk_t e;
        in_hs = 0; wait_cnt = 0; cur_ok = 1'b0;
        e.x = '0; e.y = '0; e.ok = 1'b0; e.dly = 0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                in_hs   = 0;
                chk_ack = 1'b0;
                chk_ok  = 1'b0;
            end else begin
                chk_ack = 1'b0;
                if (in_hs) begin
                    check("chk_hold", {chk_req, chk_x, chk_y}, {1'b1, e.x, e.y});
                end else if (chk_req) begin
                    if (chk_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_chk: got (%0d,%0d) expected no request", chk_x, chk_y);
                        e.x = chk_x; e.y = chk_y; e.ok = 1'b1; e.dly = 0;
                    end else begin
                        e = chk_q.pop_front();
                        check("chk_xy", {chk_x, chk_y}, {e.x, e.y});
                        $display("chk (%0d,%0d) ok=%0b", chk_x, chk_y, e.ok);
                    end
                    in_hs    = 1;
                    wait_cnt = e.dly;
                    cur_ok   = e.ok;
                end
                if (in_hs) begin
                    if (wait_cnt == 0) begin
                        chk_ack = 1'b1;
                        chk_ok  = cur_ok;
                        in_hs   = 0;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    // Event monitor: every lock/spawn pulse must match the next expected event
    initial begin : evt_monitor
        evt_t e;
        forever begin
            @(negedge clk);
            if (!rst && (lock_pulse || spawn_pulse)) begin
                if (evt_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got lock=%0b spawn=%0b pos=(%0d,%0d) expected none",
                             lock_pulse, spawn_pulse, pos_x, pos_y);
                end else begin
                    e = evt_q.pop_front();
                    check(e.is_lock ? "lock_pulse" : "spawn_pulse",
                          {lock_pulse, spawn_pulse, pos_x, pos_y},
                          {e.is_lock, ~e.is_lock, e.x, e.y});
                    $display("%s at (%0d,%0d)", e.is_lock ? "lock" : "spawn", pos_x, pos_y);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_chk_req", chk_req, 0);
        check("rst_chk_xy", {chk_x, chk_y}, 10'd0);
        check("rst_pos", {pos_x, pos_y}, {5'd5, 5'd0});
        check("rst_busy", busy, 0);
        check("rst_pulses", {lock_pulse, spawn_pulse}, 2'b00);
        rst = 1'b0;

        // Single left move with one-cycle checker delay
        push_chk(5'd4, 5'd0, 1'b1, 1);
        left_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        left_req = 1'b0;
        check("left_req_rise", chk_req, 1);
        check("left_pos_n", pos_x, 5);
        @(negedge clk);
        check("left_pos_n1", pos_x, 5);
        @(negedge clk);
        check("left_pos_n2", pos_x, 4);

        // Walk to the left wall, then hold left against it
        push_chk(5'd3, 5'd0, 1'b1, 1);
        push_chk(5'd2, 5'd0, 1'b1, 1);
        push_chk(5'd1, 5'd0, 1'b1, 1);
        push_chk(5'd0, 5'd0, 1'b1, 1);
        left_req = 1'b1;
        wait_pos(5'd0, 5'd0, 40, "left_walk");
        count_req(10, "left_wall_no_req");
        left_req = 1'b0;
        check("left_wall_pos", pos_x, 0);

        // Walk to the right wall, then hold right against it
        do_reset();
        push_chk(5'd6, 5'd0, 1'b1, 1);
        push_chk(5'd7, 5'd0, 1'b1, 1);
        push_chk(5'd8, 5'd0, 1'b1, 1);
        push_chk(5'd9, 5'd0, 1'b1, 1);
        right_req = 1'b1;
        wait_pos(5'd9, 5'd0, 40, "right_walk");
        count_req(10, "right_wall_no_req");
        right_req = 1'b0;
        check("right_wall_pos", pos_x, 9);

        // Gravity cadence: ticks at edges 64 and 128, commits at 67 and 131
        do_reset();
        push_chk(5'd5, 5'd1, 1'b1, 1);
        push_chk(5'd5, 5'd2, 1'b1, 1);
        repeat (60) @(negedge clk);
        check("grav_before_1", pos_y, 0);
        repeat (10) @(negedge clk);
        check("grav_after_1", pos_y, 1);
        repeat (55) @(negedge clk);
        check("grav_before_2", pos_y, 1);
        repeat (10) @(negedge clk);
        check("grav_after_2", pos_y, 2);

        // Long stall spans ticks 128 and 192: only one extra move follows
        do_reset();
        push_chk(5'd5, 5'd1, 1'b1, 150);
        push_chk(5'd5, 5'd2, 1'b1, 1);
        push_chk(5'd5, 5'd3, 1'b1, 1);
        repeat (200) @(negedge clk);
        check("stall_hold", {chk_req, pos_y}, {1'b1, 5'd0});
        repeat (30) @(negedge clk);
        check("stall_one_extra", pos_y, 2);
        repeat (20) @(negedge clk);
        check("stall_no_accum", pos_y, 2);
        repeat (15) @(negedge clk);
        check("stall_next_tick", pos_y, 3);

        // Asynchronous reset mid-CHECK with gravity pending
        do_reset();
        push_chk(5'd5, 5'd1, 1'b1, 1);
        drop_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drop_req = 1'b0;
        wait_pos(5'd5, 5'd1, 20, "mid_drop");
        push_chk(5'd5, 5'd2, 1'b1, 300);
        n = 0;
        while (!chk_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_chk_seen", chk_req, 1);
        repeat (70) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_chk_req", chk_req, 0);
        check("mid_rst_pos", {pos_x, pos_y}, {5'd5, 5'd0});
        check("mid_rst_busy", busy, 0);
        check("mid_rst_chk_xy", {chk_x, chk_y}, 10'd0);
        @(negedge clk);
        rst = 1'b0;
        count_req(40, "mid_rst_pend_cleared");

        // Reach (3,7), then a failed drop locks and respawns; left is ignored
        do_reset();
        for (int i = 1; i <= 7; i++) push_chk(5'd5, 5'(i), 1'b1, 1);
        drop_req = 1'b1;
        wait_pos(5'd5, 5'd7, 40, "lock_setup_drop");
        drop_req = 1'b0;
        push_chk(5'd4, 5'd7, 1'b1, 1);
        push_chk(5'd3, 5'd7, 1'b1, 1);
        left_req = 1'b1;
        wait_pos(5'd3, 5'd7, 20, "lock_setup_left");
        left_req = 1'b0;
        push_chk(5'd3, 5'd8, 1'b0, 1);
        push_evt(1'b1, 5'd3, 5'd7);
        push_evt(1'b0, 5'd5, 5'd0);
        drop_req = 1'b1;
        left_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drop_req = 1'b0;
        left_req = 1'b0;
        n = 0;
        while (!lock_pulse && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lock_seen", lock_pulse, 1);
        @(negedge clk);
        check("spawn_follows_lock", spawn_pulse, 1);
        repeat (3) @(negedge clk);
        check("after_spawn", {chk_req, pos_x, pos_y}, {1'b0, 5'd5, 5'd0});

`ifdef TETRIS_HARD_DROP_EN
        // Hard drop: rows 1..12 free, row 13 blocked
        do_reset();
        for (int i = 1; i <= 12; i++) push_chk(5'd5, 5'(i), 1'b1, 0);
        push_chk(5'd5, 5'd13, 1'b0, 0);
        push_evt(1'b1, 5'd5, 5'd12);
        push_evt(1'b0, 5'd5, 5'd0);
        hard_drop_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hard_drop_req = 1'b0;
        n = 0;
        begin
            int idle_cnt = 0;
            while (!spawn_pulse && n < 60) begin
                if (!busy) idle_cnt++;
                @(negedge clk);
                n++;
            end
            check("hd_busy_held", idle_cnt, 0);
        end
        check("hd_spawn_seen", spawn_pulse, 1);
        repeat (2) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        check("final_queues_drained", chk_q.size() + evt_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tetris_move_ctrl.md
Name: tetris_move_ctrl

Overview:
- Sequences all motion of the falling piece: gravity ticks and player left/right/soft-drop requests.
- Arbitrates between requesters and proposes one candidate position at a time to the board collision checker over a req/ack handshake.
- Commits the move only if the checker reports it legal. Locks the piece and respawns it when a downward move is illegal.
- Sits between the input debouncers, the board/collision unit and the renderer. Holds the authoritative piece position.

Parameters:
- GRAV_DIV, 25000000, clk cycles between gravity ticks (must be >= 2)
- X_MAX, 9, rightmost legal column index
- SPAWN_X, 5, column loaded at reset and on respawn
- SPAWN_Y, 0, row loaded at reset and on respawn

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- left_req  in  1  level; request one column left
- right_req  in  1  level; request one column right
- drop_req  in  1  level; request one row down (soft drop)
- chk_req  out  1  candidate position valid, held until chk_ack
- chk_x  out  5  candidate column
- chk_y  out  5  candidate row
- chk_ack  in  1  one-cycle pulse; chk_ok is valid in the same cycle
- chk_ok  in  1  1 = candidate free and in bounds
- pos_x  out  5  committed piece column
- pos_y  out  5  committed piece row
- lock_pulse  out  1  one-cycle pulse: piece fixed at pos_x/pos_y
- spawn_pulse  out  1  one-cycle pulse: new piece placed at spawn
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state) values:
  - pos_x=SPAWN_X, pos_y=SPAWN_Y; state=IDLE; gravity counter=0; grav_pend=0.
  - chk_req=0, chk_x/chk_y=0, lock_pulse=0, spawn_pulse=0, busy=0.
- Gravity counter: increments every cycle, in every state.
  - On reaching GRAV_DIV-1 it wraps to 0 and sets grav_pend.
  - grav_pend clears only when a gravity move is launched.
  - A second tick while grav_pend is already set is dropped; ticks do not accumulate.
- States: IDLE, CHECK, LOCK, SPAWN.
- IDLE arbitration: fixed priority grav_pend > drop_req > left_req > right_req. One move is launched per visit to IDLE.
  - Down move (gravity or drop): candidate = (pos_x, pos_y+1). Go to CHECK.
  - Left move: if pos_x==0, reject with no handshake and stay in IDLE. Otherwise candidate = (pos_x-1, pos_y). Go to CHECK.
  - Right move: if pos_x==X_MAX, reject with no handshake and stay in IDLE. Otherwise candidate = (pos_x+1, pos_y). Go to CHECK.
  - A rejected left/right consumes the cycle. Lower-priority requests are not tried in that same cycle.
  - Candidate arithmetic is 5-bit. pos_y+1 at 31 wraps to 0; the checker is responsible for flagging this out of bounds.
- CHECK:
  - chk_req is registered: it asserts on the cycle after the launch decision and holds, with chk_x/chk_y, stable until chk_ack.
  - chk_ack with chk_ok=1: commit candidate to pos_x/pos_y on that edge. Deassert chk_req and return to IDLE.
  - chk_ack with chk_ok=0, horizontal move: position unchanged, return to IDLE.
  - chk_ack with chk_ok=0, down move: go to LOCK.
  - chk_ack arriving while not in CHECK is ignored.
- LOCK: lock_pulse=1 for exactly this one cycle; pos_x/pos_y still show the locked position. Next state is SPAWN.
- SPAWN: pos_x<=SPAWN_X, pos_y<=SPAWN_Y; spawn_pulse=1 for this one cycle. Next state is IDLE.
- Requests are level-sensitive. A held left_req repeats one move per completed IDLE->CHECK->IDLE round trip. Input edge/auto-repeat shaping is done upstream.
- Minimum latency: request sampled in IDLE at edge N; chk_req high after edge N; if chk_ack arrives in the cycle after that, pos_x/pos_y update at edge N+2.

Optional Feature:
- Macro: TETRIS_HARD_DROP_EN.
- Defined:
  - Adds input port hard_drop_req (1 bit). In IDLE it has the highest priority, above grav_pend.
  - Enters an internal hard-drop mode that issues consecutive down checks, committing each chk_ok=1, with no return to IDLE between them.
  - First chk_ok=0 goes to LOCK then SPAWN as normal. grav_pend is cleared on entry to hard-drop mode.
  - busy stays high throughout.
- Undefined: the port is absent and behaviour is exactly as described above.

Test Plan:
- Reset mid-CHECK (chk_req=1) -> same cycle: chk_req=0, pos=(5,0), busy=0; pending gravity cleared.
- pos=(5,0), left_req=1, checker acks ok after 1 cycle -> chk=(4,0), then pos_x=4 two edges after the request was sampled; no lock_pulse.
- pos_x=0, left_req held 10 cycles -> chk_req never asserts, pos_x stays 0. Likewise right_req with pos_x=9.
- GRAV_DIV=4, no requests, checker always ok -> pos_y increments by 1 every ~4 cycles; two ticks during a long CHECK stall yield only one extra move.
- pos=(3,7), drop_req and left_req together, checker returns chk_ok=0 for chk=(3,8) -> lock_pulse with pos=(3,7), next cycle spawn_pulse with pos=(5,0); left is not applied.
- TETRIS_HARD_DROP_EN defined: pos=(5,0), hard_drop_req, checker ok for y<=12 -> pos_y steps 1..12, then lock_pulse at (5,12), then spawn.
